// File: rtl/dotn_acc.sv
// dotn_acc: pipelined signed LANES-wide dot product with multi-beat row accumulation.
// Define DOTN_SATURATE_EN to clamp each accumulation on overflow instead of wrapping.
module dotn_acc #(
    parameter int IWIDTH = 8,
    parameter int LANES  = 8,
    parameter int OWIDTH = 32,
    parameter int CWIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [IWIDTH*LANES-1:0]    vec0,
    input  logic [IWIDTH*LANES-1:0]    vec1,
    input  logic                       ivalid,
    input  logic                       ilast,
    output logic signed [OWIDTH-1:0]   result,
    output logic [CWIDTH-1:0]          nbeats,
    output logic                       ovf,
    output logic                       ovalid
);
    localparam int K  = $clog2(LANES);
    localparam int PW = 2 * IWIDTH;
    localparam int TW = PW + K;

    logic [IWIDTH*LANES-1:0] a_r, b_r;
    logic                    iv_r, il_r;
    logic [K:0]              vp, lp;

    always_ff @(posedge clk) begin
        iv_r <= rst ? 1'b0 : ivalid;
        vp   <= rst ? '0 : {vp[K-1:0], iv_r};
        il_r <= ilast;
        lp   <= {lp[K-1:0], il_r};
        a_r  <= vec0;
        b_r  <= vec1;
    end

    // Level 0 holds the products; each later level halves the count and grows one bit.
    for (genvar g = 0; g <= K; g++) begin : lv
        logic signed [PW+g-1:0] s [LANES>>g];
        if (g == 0) begin : m
            always_ff @(posedge clk)
                for (int i = 0; i < LANES; i++)
                    s[i] <= PW'($signed(a_r[i*IWIDTH +: IWIDTH])) * PW'($signed(b_r[i*IWIDTH +: IWIDTH]));
        end else begin : t
            always_ff @(posedge clk)
                for (int i = 0; i < (LANES >> g); i++)
                    s[i] <= {lv[g-1].s[2*i][PW+g-2], lv[g-1].s[2*i]}
                          + {lv[g-1].s[2*i+1][PW+g-2], lv[g-1].s[2*i+1]};
        end
    end

    logic signed [TW-1:0]     tsum;
    logic signed [OWIDTH-1:0] acc, ext, sum_w, nacc;
    logic [CWIDTH-1:0]        cnt, cnt_n;
    logic                     of, ovs;

    assign tsum = lv[K].s[0];

    always_comb begin
        ext   = OWIDTH'(tsum);
        sum_w = acc + ext;
        of    = (acc[OWIDTH-1] == ext[OWIDTH-1]) && (sum_w[OWIDTH-1] != acc[OWIDTH-1]);
`ifdef DOTN_SATURATE_EN
        nacc  = of ? (acc[OWIDTH-1] ? {1'b1, {(OWIDTH-1){1'b0}}} : {1'b0, {(OWIDTH-1){1'b1}}}) : sum_w;
`else
        nacc  = sum_w;
`endif
        cnt_n = &cnt ? cnt : cnt + CWIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            cnt    <= '0;
            ovs    <= 1'b0;
            result <= '0;
            nbeats <= '0;
            ovf    <= 1'b0;
            ovalid <= 1'b0;
        end else begin
            ovalid <= 1'b0;
            if (vp[K] && lp[K]) begin
                result <= nacc;
                nbeats <= cnt_n;
                ovf    <= ovs | of;
                ovalid <= 1'b1;
                acc    <= '0;
                cnt    <= '0;
                ovs    <= 1'b0;
            end else if (vp[K]) begin
                acc    <= nacc;
                cnt    <= cnt_n;
                ovs    <= ovs | of;
            end
        end
    end
endmodule

// File: tb/tb_dotn_acc.sv
// tb_dotn_acc: scoreboard bench driving a 32-bit and a 20-bit accumulator with shared stimulus.
module tb_dotn_acc;
    typedef struct {
        longint r;
        longint nb;
        longint o;
        longint c;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [63:0]         vec0, vec1;
    logic                ivalid, ilast;
    logic signed [31:0]  r32;
    logic [15:0]         nb32;
    logic                ov32, ovv32;
    logic signed [19:0]  r20;
    logic [15:0]         nb20;
    logic                ov20, ovv20;

    exp_t q32[$];
    exp_t q20[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    localparam logic [63:0] A   = {8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    localparam logic [63:0] B   = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    localparam logic [63:0] M   = {8{8'h80}};
    localparam logic [63:0] P   = {8{8'h7f}};
    localparam logic [63:0] Z   = 64'd0;
`ifdef DOTN_SATURATE_EN
    localparam longint OVR = 524287;
`else
    localparam longint OVR = -403416;
`endif

    dotn_acc u32 (.clk(clk), .rst(rst), .vec0(vec0), .vec1(vec1), .ivalid(ivalid), .ilast(ilast),
                  .result(r32), .nbeats(nb32), .ovf(ov32), .ovalid(ovv32));
    dotn_acc #(.OWIDTH(20)) u20 (.clk(clk), .rst(rst), .vec0(vec0), .vec1(vec1), .ivalid(ivalid),
                  .ilast(ilast), .result(r20), .nbeats(nb20), .ovf(ov20), .ovalid(ovv20));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ovv32) begin
            if (q32.size() == 0) chk("u32 unexpected ovalid", r32, -1);
            else begin
                e = q32.pop_front();
                chk("u32 result", r32, e.r);
                chk("u32 nbeats", nb32, e.nb);
                chk("u32 ovf", ov32, e.o);
                chk("u32 latency", cyc, e.c);
            end
        end
        if (!rst && ovv20) begin
            if (q20.size() == 0) chk("u20 unexpected ovalid", r20, -1);
            else begin
                e = q20.pop_front();
                chk("u20 result", r20, e.r);
                chk("u20 nbeats", nb20, e.nb);
                chk("u20 ovf", ov20, e.o);
                chk("u20 latency", cyc, e.c);
            end
        end
    end

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic last,
                        input longint r, input longint nb, input longint r2, input longint o2);
        @(negedge clk);
        vec0 = a;
        vec1 = b;
        ivalid = 1'b1;
        ilast = last;
        if (last) begin
            q32.push_back('{r, nb, 0, cyc + 6});
            q20.push_back('{r2, nb, o2, cyc + 6});
        end
    endtask

    task automatic idle(input int n, input logic lst);
        repeat (n) begin
            @(negedge clk);
            ivalid = 1'b0;
            ilast = lst;
            vec0 = P;
            vec1 = P;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        ivalid = 1'b0;
        ilast = 1'b0;
        vec0 = Z;
        vec1 = Z;
        repeat (3) @(negedge clk);
        chk("reset result", r32, 0);
        chk("reset nbeats", nb32, 0);
        chk("reset ovf", ov32, 0);
        chk("reset ovalid", ovv32, 0);
        chk("reset ovalid u20", ovv20, 0);
        rst = 1'b0;
        send(A, B, 1, 169, 1, 169, 0);
        idle(8, 0);
        send(M, M, 1, 131072, 1, 131072, 0);
        send(M, P, 1, -130048, 1, -130048, 0);
        idle(8, 0);
        // ilast held high during bubbles must not close the row
        send(A, B, 0, 0, 0, 0, 0);
        idle(2, 1);
        send(A, B, 0, 0, 0, 0, 0);
        idle(2, 1);
        send(A, B, 1, 507, 3, 507, 0);
        idle(8, 0);
        send(A, B, 1, 169, 1, 169, 0);
        send(Z, Z, 1, 0, 1, 0, 0);
        send(M, M, 1, 131072, 1, 131072, 0);
        send(A, B, 1, 169, 1, 169, 0);
        idle(8, 0);
        repeat (4) send(P, P, 0, 0, 0, 0, 0);
        send(P, P, 1, 645160, 5, OVR, 1);
        idle(8, 0);
        send(A, B, 0, 0, 0, 0, 0);
        send(A, B, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        ivalid = 1'b0;
        ilast = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        send(A, B, 1, 169, 1, 169, 0);
        idle(12, 0);
        chk("u32 queue drained", q32.size(), 0);
        chk("u20 queue drained", q20.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dotn_acc.md
# dotn_acc

Parametrised, fully pipelined signed dot-product engine with multi-beat row accumulation, the successor to `dot8` in the matrix-vector multiplier datapath. Each accepted beat multiplies `LANES` pairs of signed elements, reduces them through a registered adder tree, and adds the sum into a row accumulator. A row may span any number of beats, so matrix rows longer than `LANES` are handled without external summation. One row result is emitted per `ilast` beat, and back-to-back rows run at full throughput.

## Interface
Parameters:
- `IWIDTH`, 8, signed element width.
- `LANES`, 8, elements per vector beat; must be a power of 2 and at least 2.
- `OWIDTH`, 32, signed result/accumulator width; must be at least 2*IWIDTH + log2(LANES).
- `CWIDTH`, 16, width of the beat counter.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `vec0`  in  IWIDTH*LANES  operand A; lane i is at `[i*IWIDTH +: IWIDTH]`, signed.
- `vec1`  in  IWIDTH*LANES  operand B, same packing.
- `ivalid`  in  1  beat valid; no backpressure, every valid beat is consumed.
- `ilast`  in  1  marks the final beat of a row; qualified by `ivalid`.
- `result`  out  OWIDTH  signed row dot product.
- `nbeats`  out  CWIDTH  number of beats in the completed row.
- `ovf`  out  1  set if any accumulation in the row overflowed OWIDTH.
- `ovalid`  out  1  one-cycle strobe; `result`, `nbeats` and `ovf` are valid while it is high.

## Operation
- Stage M: LANES signed products of 2*IWIDTH bits are registered, together with `ivalid` and `ilast`.
- Stages T1..Tk, with k = log2(LANES): a binary adder tree with one registered level per stage. Each level grows the width by 1 bit with sign extension. Valid and last travel alongside.
- Stage A: the tree sum is sign-extended to OWIDTH and added to `acc`. Adds occur only when the tree-output valid is high; bubbles leave `acc` unchanged.
  - On a valid beat with last=0: `acc <= acc + sum`, `cnt <= cnt + 1`.
  - On a valid beat with last=1: `result <= acc + sum`, `nbeats <= cnt + 1`, `ovalid <= 1`, and `acc`, `cnt` and the overflow flag are cleared in the same cycle. The next row's first beat may arrive on the following cycle.
- A single-beat row (`ivalid` and `ilast` both high) produces `nbeats` = 1.
- `cnt` saturates at 2^CWIDTH-1 and does not wrap.
- Overflow is detected as the sign of (acc + sum) differing from both operand signs when they agree. The flag is sticky within the row and reported on `ovf`.
- `ilast` while `ivalid` is low is ignored.
- Reset: all pipeline valid bits, `acc`, `cnt` and the overflow flag are cleared. Any partial row or in-flight beats are discarded with no `ovalid`.

## Timing
- Reset values: `result` = 0, `nbeats` = 0, `ovf` = 0, `ovalid` = 0.
- Latency from the `ilast` beat sampled at edge n to `ovalid` high after edge n + k + 2. For LANES=8 this is 5 cycles.
- Throughput is one beat per cycle, with one result per cycle possible when every beat is a single-beat row.
- `ovalid` is high for exactly one cycle per row. Outputs hold their values between strobes.
- If `rst` is asserted in the same cycle as a completing row, reset wins and no `ovalid` is produced.

## Configuration
- `DOTN_SATURATE_EN` defined: each accumulation clamps to the range [-2^(OWIDTH-1), 2^(OWIDTH-1)-1] on overflow. The clamped value is the new `acc` (per-add clamping), and `ovf` is still reported.
- `DOTN_SATURATE_EN` not defined: accumulation wraps modulo 2^OWIDTH, and `ovf` still flags the wrap.
- Ports, latency and reset behaviour are identical in both builds.

## Test plan
- Defaults, single beat: vec0 lanes 0..7 = 7,6,5,4,3,2,1,1 and vec1 lanes 0..7 = 8,7,6,5,4,3,2,1, with ilast=1 -> `result` = 169, `nbeats` = 1, `ovf` = 0, `ovalid` exactly 5 cycles later for 1 cycle.
- Signed extremes: all lanes -128 × -128 in a single beat -> `result` = 131072. Then all lanes -128 × 127 -> `result` = -130048.
- Multi-beat with bubbles: the 169 vectors sent 3 times, with ivalid low for 2 cycles between beats and ilast on the 3rd -> one strobe with `result` = 507 and `nbeats` = 3, and no earlier strobe.
- Back-to-back rows: 4 consecutive single-beat rows of 169, 0 (all-zero vectors), 131072 and 169 -> 4 strobes on consecutive cycles with those values in order.
- Overflow, OWIDTH=20: 5 beats of all-lanes 127 × 127 (129032 per beat), ilast on beat 5 -> with the macro, `result` = 524287 and `ovf` = 1. Without the macro, `result` = -403416 and `ovf` = 1.
- Reset mid-row: 2 beats of 169, `rst` for 1 cycle, then a single beat of 169 with ilast -> only one strobe, with `result` = 169 and `nbeats` = 1.
